// File: rtl/alu.sv
// Registered 64-bit integer ALU for the x86-64 execute stage.
// Decodes the x86 primary opcode byte and returns result, write enable,
// illegal indication and {OF,SF,ZF,AF,PF,CF} one cycle after in_valid.
// Build option: define ALU_FLAGS_EN to include the status-flag logic;
// without it the flag logic is omitted and flags read as 0.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  oper,
  input  logic [63:0] oper1,
  input  logic [63:0] oper2,
  input  logic        cf_in,
  output logic        out_valid,
  output logic [63:0] alu_res,
  output logic        wr_en,
  output logic        illegal,
  output logic [5:0]  flags
);

  logic        r_out_valid;
  logic [63:0] r_alu_res;
  logic        r_wr_en;
  logic        r_illegal;

  logic        w_grp_legal;
  logic        w_test;
  logic        w_mov;
  logic        w_cin;
  logic [63:0] w_sum;
  logic [63:0] w_diff;
  logic [63:0] w_res;
  logic        w_wr_en;
  logic        w_illegal;

  // 0x00-0x3F groups only use row entries 0-5; 6/7 are other instructions
  assign w_grp_legal = (oper[7:6] == 2'b00) && (oper[2:0] <= 3'd5);
  assign w_test      = (oper[7:1] == 7'b1000010);
  assign w_mov       = (oper[7:2] == 6'b100010);
  // Carry-in only feeds ADC (group 2) and SBB (group 3)
  assign w_cin       = (oper[5:4] == 2'b01) & cf_in;

`ifdef ALU_FLAGS_EN
  logic w_add_co;
  logic w_sub_bo;
  assign {w_add_co, w_sum}  = {1'b0, oper1} + {1'b0, oper2} + {64'd0, w_cin};
  assign {w_sub_bo, w_diff} = {1'b0, oper1} - {1'b0, oper2} - {64'd0, w_cin};
`else
  assign w_sum  = oper1 + oper2 + {63'd0, w_cin};
  assign w_diff = oper1 - oper2 - {63'd0, w_cin};
`endif

  // Result and write-back decode
  always_comb begin
    w_res     = '0;
    w_wr_en   = 1'b0;
    w_illegal = 1'b0;
    if (w_grp_legal) begin
      w_wr_en = 1'b1;
      case (oper[5:3])
        3'd0, 3'd2: w_res = w_sum;
        3'd3, 3'd5: w_res = w_diff;
        3'd1:       w_res = oper1 | oper2;
        3'd4:       w_res = oper1 & oper2;
        3'd6:       w_res = oper1 ^ oper2;
        default: begin
          w_res   = oper1;
          w_wr_en = 1'b0;
        end
      endcase
    end else if (w_test) begin
      w_res = oper1;
    end else if (w_mov) begin
      w_res   = oper2;
      w_wr_en = 1'b1;
    end else begin
      w_illegal = 1'b1;
    end
  end

  // Output registers; all hold while in_valid is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_alu_res   <= '0;
      r_wr_en     <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_alu_res <= w_res;
        r_wr_en   <= w_wr_en;
        r_illegal <= w_illegal;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign alu_res   = r_alu_res;
  assign wr_en     = r_wr_en;
  assign illegal   = r_illegal;

`ifdef ALU_FLAGS_EN
  localparam logic [1:0] F_NONE  = 2'd0;
  localparam logic [1:0] F_LOGIC = 2'd1;
  localparam logic [1:0] F_ADD   = 2'd2;
  localparam logic [1:0] F_SUB   = 2'd3;

  logic [63:0] w_fres;
  logic [1:0]  w_fkind;
  logic [5:0]  w_flags;
  logic [5:0]  r_flags;

  // Flag-source value; CMP/TEST produce flags from a value never written back
  always_comb begin
    w_fres  = '0;
    w_fkind = F_NONE;
    if (w_grp_legal) begin
      case (oper[5:3])
        3'd0, 3'd2: begin w_fres = w_sum;         w_fkind = F_ADD;   end
        3'd3, 3'd5,
        3'd7:       begin w_fres = w_diff;        w_fkind = F_SUB;   end
        3'd1:       begin w_fres = oper1 | oper2; w_fkind = F_LOGIC; end
        3'd4:       begin w_fres = oper1 & oper2; w_fkind = F_LOGIC; end
        default:    begin w_fres = oper1 ^ oper2; w_fkind = F_LOGIC; end
      endcase
    end else if (w_test) begin
      w_fres  = oper1 & oper2;
      w_fkind = F_LOGIC;
    end
  end

  // Flag vector {OF,SF,ZF,AF,PF,CF}; AF is the carry into bit 4
  always_comb begin
    w_flags    = '0;
    w_flags[4] = w_fres[63];
    w_flags[3] = (w_fres == 64'd0);
    w_flags[1] = ~^w_fres[7:0];
    if (w_fkind == F_ADD) begin
      w_flags[0] = w_add_co;
      w_flags[2] = oper1[4] ^ oper2[4] ^ w_fres[4];
      w_flags[5] = (oper1[63] == oper2[63]) && (w_fres[63] != oper1[63]);
    end else if (w_fkind == F_SUB) begin
      w_flags[0] = w_sub_bo;
      w_flags[2] = oper1[4] ^ oper2[4] ^ w_fres[4];
      w_flags[5] = (oper1[63] != oper2[63]) && (w_fres[63] != oper1[63]);
    end
  end

  // MOV and illegal opcodes leave the flags untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else if (in_valid && (w_fkind != F_NONE)) begin
      r_flags <= w_flags;
    end
  end

  assign flags = r_flags;
`else
  assign flags = 6'd0;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes hand-computed expectations,
// a monitor pops and compares whenever out_valid is seen.
module tb_alu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  oper;
  logic [63:0] oper1;
  logic [63:0] oper2;
  logic        cf_in;
  logic        out_valid;
  logic [63:0] alu_res;
  logic        wr_en;
  logic        illegal;
  logic [5:0]  flags;

`ifdef ALU_FLAGS_EN
  localparam logic FLAGS_ON = 1'b1;
`else
  localparam logic FLAGS_ON = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [63:0] res;
    logic        wr;
    logic        ill;
    logic [5:0]  fl;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   checks   = 0;
  int   failures = 0;

  alu dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .oper     (oper),
    .oper1    (oper1),
    .oper2    (oper2),
    .cf_in    (cf_in),
    .out_valid(out_valid),
    .alu_res  (alu_res),
    .wr_en    (wr_en),
    .illegal  (illegal),
    .flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] fx(input logic [5:0] f);
    return f & {6{FLAGS_ON}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic issue(input string nm, input logic [7:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic c, input logic [63:0] r,
                       input logic w, input logic il, input logic [5:0] f);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    oper     = op;
    oper1    = a;
    oper2    = b;
    cf_in    = c;
    e.name = nm;
    e.res  = r;
    e.wr   = w;
    e.ill  = il;
    e.fl   = fx(f);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic clear_last();
    last_exp.name = "reset";
    last_exp.res  = '0;
    last_exp.wr   = 1'b0;
    last_exp.ill  = 1'b0;
    last_exp.fl   = '0;
  endtask

  // Monitor: compare on out_valid, otherwise verify outputs are held
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out_valid actual=1 required=0");
          end else begin
            e = sb_q.pop_front();
            chk({e.name, ".res"},     alu_res,         e.res);
            chk({e.name, ".wr_en"},   {63'd0, wr_en},  {63'd0, e.wr});
            chk({e.name, ".illegal"}, {63'd0, illegal}, {63'd0, e.ill});
            chk({e.name, ".flags"},   {58'd0, flags},  {58'd0, e.fl});
            last_exp = e;
          end
        end else begin
          chk("hold.res",     alu_res,          last_exp.res);
          chk("hold.wr_en",   {63'd0, wr_en},   {63'd0, last_exp.wr});
          chk("hold.illegal", {63'd0, illegal}, {63'd0, last_exp.ill});
          chk("hold.flags",   {58'd0, flags},   {58'd0, last_exp.fl});
        end
      end
    end
  end

  initial begin
    clear_last();
    reset    = 1'b1;
    in_valid = 1'b0;
    oper     = '0;
    oper1    = '0;
    oper2    = '0;
    cf_in    = 1'b0;
    #1;
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst.res",       alu_res,            64'd0);
    chk("rst.wr_en",     {63'd0, wr_en},     64'd0);
    chk("rst.illegal",   {63'd0, illegal},   64'd0);
    chk("rst.flags",     {58'd0, flags},     64'd0);
    #11 reset = 1'b0;

    //     name       op     oper1                  oper2                  cf  result                 wr ill flags {OF,SF,ZF,AF,PF,CF}
    issue("sub",      8'h2A, 64'd12,                64'd23,                0, 64'hFFFF_FFFF_FFFF_FFF5, 1, 0, 6'b010011);
    issue("add_ovf",  8'h01, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,               0, 64'h8000_0000_0000_0000, 1, 0, 6'b110110);
    issue("adc_wrap", 8'h11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,               1, 64'd0,                 1, 0, 6'b001111);
    issue("cmp_eq",   8'h39, 64'd5,                 64'd5,                 0, 64'd5,                 0, 0, 6'b001010);
    issue("illegal",  8'h0F, 64'h1234,              64'h5678,              0, 64'd0,                 0, 1, 6'b001010);
    issue("xor",      8'h31, 64'hF0,                64'hFF,                0, 64'h0F,                1, 0, 6'b000010);
    issue("mov",      8'h89, 64'd1,                 64'h1234,              1, 64'h1234,              1, 0, 6'b000010);
    issue("sbb",      8'h19, 64'h10,                64'h1,                 1, 64'h0E,                1, 0, 6'b000100);
    issue("test",     8'h85, 64'hF0,                64'h0F,                0, 64'hF0,                0, 0, 6'b001010);
    issue("and",      8'h21, 64'hFFFF_0000_0000_00FF, 64'h8000_0000_0000_0F0F, 1, 64'h8000_0000_0000_000F, 1, 0, 6'b010010);
    issue("or",       8'h09, 64'h3,                 64'h4,                 0, 64'h7,                 1, 0, 6'b000000);
    issue("grp_row6", 8'h06, 64'h3,                 64'h4,                 0, 64'd0,                 0, 1, 6'b000000);
    issue("sub_ovf",  8'h29, 64'h8000_0000_0000_0000, 64'd1,               0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 6'b100110);
    idle(2);

    issue("adc_nc",   8'h13, 64'd1,                 64'd2,                 0, 64'd3,                 1, 0, 6'b000010);
    // Next op is in flight when reset hits and must be discarded
    @(negedge clk);
    in_valid = 1'b1;
    oper     = 8'h01;
    oper1    = 64'd1;
    oper2    = 64'd1;
    cf_in    = 1'b0;
    #1;
    chk("pre_rst.out_valid", {63'd0, out_valid}, 64'd1);
    reset = 1'b1;
    clear_last();
    #1;
    chk("async_rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst.res",       alu_res,            64'd0);
    chk("async_rst.wr_en",     {63'd0, wr_en},     64'd0);
    chk("async_rst.illegal",   {63'd0, illegal},   64'd0);
    chk("async_rst.flags",     {58'd0, flags},     64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    idle(2);

    issue("xor_zero", 8'h33, 64'hAA,                64'hAA,                0, 64'd0,                 1, 0, 6'b001010);
    idle(3);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
